sr_cmd_conditioner: RTL
=======================

// Module: sr_cmd_conditioner
// PURPOSE
//   Upstream command stage for the set/reset flip-flop. Turns two raw, bouncy, asynchronous
//   push-button inputs (set, clear) into clean single-cycle S/R pulses.
//   Never presents S=R=1 downstream; a simultaneous request is arbitrated and flagged.
//   Sits between the board I/O pins and the S/R inputs of the flip-flop stage.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable samples needed to accept a level change (>=2)
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived; do not override)
//   SET_WINS         0   simultaneous pulses: 0 = clear wins, 1 = set wins
// PORTS
//   clk      in   1  clock; all state on rising edge
//   rst      in   1  asynchronous, active-high reset
//   set_btn  in   1  raw set request, asynchronous, active-high
//   clr_btn  in   1  raw clear request, asynchronous, active-high
//   s_out    out  1  registered one-cycle set pulse to the flip-flop S input
//   r_out    out  1  registered one-cycle reset pulse to the flip-flop R input
//   conflict out  1  one-cycle pulse: both channels accepted a press in the same cycle
//   set_lvl  out  1  debounced level of set_btn
//   clr_lvl  out  1  debounced level of clr_btn
// BEHAVIOUR
//   Reset: all outputs 0, sync flops 0, counters 0, both channel FSMs in ST_LO. Asserting rst
//     mid-debounce aborts the pending change with no pulse; after release, a button held high
//     is re-qualified from zero (full DEBOUNCE_CYCLES).
//   Per-channel FSM on the synchronised input x:
//     ST_LO: x=1 -> ST_RISE, cnt=1; else stay, cnt=0.
//     ST_RISE: x=0 -> ST_LO, cnt=0 (bounce); x=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HI, lvl=1;
//       otherwise cnt++.
//     ST_HI: x=0 -> ST_FALL, cnt=1; else stay.
//     ST_FALL: x=1 -> ST_HI, cnt=0 (bounce); x=0 and cnt==DEBOUNCE_CYCLES-1 -> ST_LO, lvl=0;
//       otherwise cnt++.
//     The channel raises press for one cycle on the ST_RISE->ST_HI transition only. Release
//     produces no pulse.
//   Counter never wraps; it saturates at DEBOUNCE_CYCLES-1 before the state change.
//   Arbitration (registered, 1 cycle):
//     set_press only -> s_out=1
//     clr_press only -> r_out=1
//     both -> only the winner per SET_WINS pulses, and conflict=1
//   Invariant: s_out & r_out == 0 in every cycle.
//   Latency: raw edge -> s_out/r_out = DEBOUNCE_CYCLES+3 clk (2 sync + qualify + output reg).
//     set_lvl/clr_lvl lead the pulse by 1 clk.
//   Holding a button indefinitely yields exactly one pulse. A new press needs a qualified
//     release first.
// CONFIGURATION
//   SR_CMD_SYNC_EN defined: 2-flop synchroniser on each raw input (reset 0); latency as above.
//   SR_CMD_SYNC_EN undefined: inputs used directly and must already be synchronous to clk;
//     latency becomes DEBOUNCE_CYCLES+1.
// STRUCTURE
//   Shared package sr_cmd_pkg:
//     state encoding ST_LO/ST_RISE/ST_HI/ST_FALL (2-bit)
//     SET_WINS encodings PRIO_CLR=0, PRIO_SET=1
//   Sub-module sr_debounce_ch (sync + FSM + counter; outputs lvl, press), instantiated twice.
//     The top level holds the arbitration and output registers.
// TESTING (DEBOUNCE_CYCLES=4, SR_CMD_SYNC_EN defined)
//   1. rst=1 with set_btn=1 held -> all outputs 0; release rst -> s_out pulses once, 7 clk later.
//   2. set_btn high 10 clk, clean -> set_lvl=1 at clk 6, s_out=1 for one cycle at clk 7; r_out,
//      conflict stay 0.
//   3. clr_btn toggles 1,0,1,0,1 each clk, then holds 1 -> no pulse during toggling; r_out once,
//      7 clk after the final rise.
//   4. set_btn and clr_btn rise on the same edge, SET_WINS=0 -> r_out=1, s_out=0, conflict=1,
//      same cycle; repeat with SET_WINS=1 -> s_out=1, r_out=0, conflict=1.
//   5. set_btn held 50 clk -> exactly one s_out pulse.
//      Release for 2 clk, re-press -> no second pulse.
//      Release for 6+ clk, re-press -> second pulse.
//   6. rst asserted 2 clk into a qualifying clr_btn press -> no r_out; clr_lvl=0.
//      Random stimulus assertion throughout: s_out & r_out never 1 together.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared definitions for the S/R command conditioner
//   state_t  : per-channel debounce FSM encoding (2-bit)
//   PRIO_*   : SET_WINS encodings for simultaneous-press arbitration
package sr_cmd_pkg;
   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      ST_RISE = 2'd1,
      ST_HI   = 2'd2,
      ST_FALL = 2'd3
   } state_t;
   localparam int PRIO_CLR = 0;
   localparam int PRIO_SET = 1;
endpackage

// File: rtl/sr_cmd_conditioner_if.sv
// sr_cmd_conditioner_if: button inputs and conditioned S/R outputs
//   set_btn, clr_btn : raw button requests (driven by master)
//   s_out, r_out     : one-cycle S/R pulses
//   conflict         : one-cycle flag, both channels pressed in the same cycle
//   set_lvl, clr_lvl : debounced button levels
interface sr_cmd_conditioner_if;
   logic set_btn;
   logic clr_btn;
   logic s_out;
   logic r_out;
   logic conflict;
   logic set_lvl;
   logic clr_lvl;
   modport master (output set_btn, clr_btn, input s_out, r_out, conflict, set_lvl, clr_lvl);
   modport slave  (input set_btn, clr_btn, output s_out, r_out, conflict, set_lvl, clr_lvl);
endinterface

// File: rtl/sr_debounce_ch.sv
// sr_debounce_ch: one button channel, optional 2-flop sync, debounce FSM and counter
//   clk, rst : clock, asynchronous active-high reset
//   btn      : raw button input
//   lvl      : debounced level
//   press    : one-cycle pulse on an accepted rising level
// Build option: SR_CMD_SYNC_EN adds the 2-flop synchroniser on btn.
module sr_debounce_ch
   import sr_cmd_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 16,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic lvl,
   output logic press
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic x;
   state_t st, st_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic lvl_d, press_d;
`ifdef SR_CMD_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else     sync <= {sync[0], btn};
   assign x = sync[1];
`else
   assign x = btn;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st    <= ST_LO;
         cnt   <= '0;
         lvl   <= 1'b0;
         press <= 1'b0;
      end else begin
         st    <= st_d;
         cnt   <= cnt_d;
         lvl   <= lvl_d;
         press <= press_d;
      end
   // Counter stops at LAST: the state changes on the next agreeing sample instead of wrapping.
   always_comb begin
      st_d    = st;
      cnt_d   = cnt;
      lvl_d   = lvl;
      press_d = 1'b0;
      case (st)
         ST_LO:
            if (x) begin
               st_d  = ST_RISE;
               cnt_d = CNT_W'(1);
            end else cnt_d = '0;
         ST_RISE:
            if (!x) begin
               st_d  = ST_LO;
               cnt_d = '0;
            end else if (cnt == LAST) begin
               st_d    = ST_HI;
               cnt_d   = '0;
               lvl_d   = 1'b1;
               press_d = 1'b1;
            end else cnt_d = cnt + CNT_W'(1);
         ST_HI:
            if (!x) begin
               st_d  = ST_FALL;
               cnt_d = CNT_W'(1);
            end
         ST_FALL:
            if (x) begin
               st_d  = ST_HI;
               cnt_d = '0;
            end else if (cnt == LAST) begin
               st_d  = ST_LO;
               cnt_d = '0;
               lvl_d = 1'b0;
            end else cnt_d = cnt + CNT_W'(1);
      endcase
   end
endmodule

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: debounces set/clear buttons into exclusive one-cycle S/R pulses
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sr_cmd_conditioner_if.slave (set_btn, clr_btn in; s_out, r_out, conflict,
//              set_lvl, clr_lvl out)
// Build option: SR_CMD_SYNC_EN enables input synchronisers in both channels.
module sr_cmd_conditioner
   import sr_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SET_WINS        = PRIO_CLR
) (
   input logic clk,
   input logic rst,
   sr_cmd_conditioner_if.slave bus
);
   logic set_press, clr_press;
   localparam logic set_pri = (SET_WINS == PRIO_SET);
   sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
      .clk  (clk),
      .rst  (rst),
      .btn  (bus.set_btn),
      .lvl  (bus.set_lvl),
      .press(set_press)
   );
   sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk  (clk),
      .rst  (rst),
      .btn  (bus.clr_btn),
      .lvl  (bus.clr_lvl),
      .press(clr_press)
   );
   // Only the priority channel may pulse on a tie, so S and R are never high together.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.s_out    <= 1'b0;
         bus.r_out    <= 1'b0;
         bus.conflict <= 1'b0;
      end else begin
         bus.s_out    <= set_press & (!clr_press | set_pri);
         bus.r_out    <= clr_press & (!set_press | !set_pri);
         bus.conflict <= set_press & clr_press;
      end
endmodule
